// File: rtl/rc_offset_init_ctrl_pkg.sv
// Shared rate-control definitions: phase encoding and default constants used by
// the offset generator, the buffer model and the QP-update blocks.
package rc_offset_init_ctrl_pkg;

  typedef enum logic [1:0] {
    RC_IDLE  = 2'd0,
    RC_DELAY = 2'd1,
    RC_HOLD  = 2'd2,
    RC_RAMP  = 2'd3
  } rc_phase_e;

  localparam int RC_OFFSET_INIT  = 8192;
  localparam int RC_AVE_BLK_BITS = 128;
  localparam int RC_BLK_PIX      = 16;

endpackage

// File: rtl/rc_sat_addsub.sv
// Unsigned saturating add/subtract for a fixed-point accumulator: subtraction
// clamps at zero, addition clamps at all-ones.
module rc_sat_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] operand,
  input  logic         sub,
  output logic [W-1:0] result
);

  logic [W:0] sum;

  // NOTE: defaults first so every path assigns each output and no latch is inferred.
  always_comb begin
    sum    = '0;
    result = '0;
    if (sub) begin
      sum    = {1'b0, acc} - {1'b0, operand};
      result = sum[W] ? '0 : sum[W-1:0];
    end else begin
      sum    = {1'b0, acc} + {1'b0, operand};
      result = sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/rc_offset_init_ctrl.sv
// Rate-control initial offset: drains during the transmission delay, holds,
// then ramps by the fullness slope towards the end of the slice.
module rc_offset_init_ctrl
  import rc_offset_init_ctrl_pkg::*;
#(
  parameter int OFFSET_W     = 16,
  parameter int OFFSET_INIT  = RC_OFFSET_INIT,
  parameter int BLK_PIX      = RC_BLK_PIX,
  parameter int AVE_BLK_BITS = RC_AVE_BLK_BITS,
  parameter int SLOPE_W      = 24,
  parameter int SLOPE_FRAC   = 16,
  parameter int CNT_W        = 12
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               slice_start,
  input  logic                               blk_valid,
  input  logic [CNT_W-1:0]                   m_numBlksInSlice,
  input  logic [7:0]                         m_numBlksInLine,
  input  logic [7:0]                         r_initTxDelay,
  input  logic [15:0]                        r_rcBufferFullnessOffsetThd,
  input  logic [SLOPE_W-1:0]                 r_rcFullnessSlope,
  output logic [OFFSET_W-1:0]                m_rcOffsetInit,
  output logic [CNT_W+$clog2(BLK_PIX)-1:0]   m_numPixelsCoded,
  output logic [1:0]                         rc_phase,
  output logic                               slice_done
);

  localparam int AW     = OFFSET_W + SLOPE_FRAC;
  localparam int PIX_SH = $clog2(BLK_PIX);
  localparam int PROD_W = CNT_W + 24;
  localparam logic [AW-1:0] ACC_INIT = AW'(OFFSET_INIT) << SLOPE_FRAC;
  localparam logic [AW-1:0] DRAIN    = AW'(AVE_BLK_BITS) << SLOPE_FRAC;

  rc_phase_e          state;
  rc_phase_e          start_state;
  logic [AW-1:0]      acc;
  logic [AW-1:0]      acc_next;
  logic [AW-1:0]      operand;
  logic [CNT_W-1:0]   blk_cnt;
  logic [CNT_W-1:0]   cnt_inc;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   th_q;
  logic [CNT_W-1:0]   th_new;
  logic [7:0]         delay_q;
  logic [SLOPE_W-1:0] slope_q;
  logic [PROD_W-1:0]  th_prod;

  // Ramp threshold in blocks; a threshold beyond the slice length clamps to zero.
  always_comb begin
    th_prod = PROD_W'(m_numBlksInLine) * PROD_W'(r_rcBufferFullnessOffsetThd);
    th_new  = '0;
    if (th_prod <= PROD_W'(m_numBlksInSlice))
      th_new = m_numBlksInSlice - th_prod[CNT_W-1:0];
    if (m_numBlksInSlice == '0)
      start_state = RC_IDLE;
    else if (r_initTxDelay != 8'd0)
      start_state = RC_DELAY;
    else if (th_new == '0)
      start_state = RC_RAMP;
    else
      start_state = RC_HOLD;
  end

  assign cnt_inc = blk_cnt + 1'b1;
  assign operand = (state == RC_DELAY) ? DRAIN : AW'(slope_q);

  rc_sat_addsub #(.W(AW)) u_sat (
    .acc     (acc),
    .operand (operand),
    .sub     (state == RC_DELAY),
    .result  (acc_next)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= RC_IDLE;
      acc        <= ACC_INIT;
      blk_cnt    <= '0;
      slice_done <= 1'b0;
      num_q      <= '0;
      th_q       <= '0;
      delay_q    <= '0;
      slope_q    <= '0;
    end else if (slice_start) begin
      state      <= start_state;
      acc        <= ACC_INIT;
      blk_cnt    <= '0;
      slice_done <= (m_numBlksInSlice == '0);
      num_q      <= m_numBlksInSlice;
      th_q       <= th_new;
      delay_q    <= r_initTxDelay;
      slope_q    <= r_rcFullnessSlope;
    end else if (blk_valid && state != RC_IDLE) begin
      blk_cnt <= cnt_inc;
      if (state == RC_DELAY || state == RC_RAMP)
        acc <= acc_next;
      // The last block of the slice still applies its own update above.
      if (cnt_inc == num_q) begin
        slice_done <= 1'b1;
        state      <= RC_IDLE;
      end else begin
        case (state)
          RC_DELAY: if (cnt_inc == CNT_W'(delay_q))
                      state <= (cnt_inc >= th_q) ? RC_RAMP : RC_HOLD;
          RC_HOLD:  if (cnt_inc >= th_q) state <= RC_RAMP;
          default:  ;
        endcase
      end
    end
  end

  assign m_rcOffsetInit   = acc[AW-1:SLOPE_FRAC];
  assign m_numPixelsCoded = {blk_cnt, {PIX_SH{1'b0}}};
  assign rc_phase         = state;

endmodule

// File: doc/rc_offset_init_ctrl.md
Name: rc_offset_init_ctrl

Overview:
Rate-control initial-offset generator for the VDC-M decoder slice loop. It tracks blocks coded per slice and drives rcOffsetInit through three phases:
- Transmission-delay drain: subtract the average block budget per block.
- Hold.
- End-of-slice ramp: add the programmable fullness slope per block, in fixed point.

It sits beside the rate-control buffer model and is advanced once per decoded block.

Parameters:
OFFSET_W, 16, integer width of rcOffsetInit
OFFSET_INIT, 8192, offset loaded at slice start
BLK_PIX, 16, pixels per block (power of two)
AVE_BLK_BITS, 128, bits subtracted per delay block
SLOPE_W, 24, width of r_rcFullnessSlope
SLOPE_FRAC, 16, fractional bits of slope and internal accumulator
CNT_W, 12, width of block counters

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
slice_start  in  1  one-cycle pulse: latch config, restart tracking
blk_valid  in  1  one-cycle pulse per decoded block
m_numBlksInSlice  in  CNT_W  blocks in slice
m_numBlksInLine  in  8  blocks per line
r_initTxDelay  in  8  delay length in blocks
r_rcBufferFullnessOffsetThd  in  16  ramp threshold in lines
r_rcFullnessSlope  in  SLOPE_W  per-block ramp increment, SLOPE_FRAC fraction bits
m_rcOffsetInit  out  OFFSET_W  current offset (integer part)
m_numPixelsCoded  out  CNT_W+log2(BLK_PIX)  blk_cnt*BLK_PIX
rc_phase  out  2  0 IDLE, 1 DELAY, 2 HOLD, 3 RAMP
slice_done  out  1  high once all blocks of slice counted

Behaviour:
- Reset (rstn=0, async):
  - state=IDLE, blk_cnt=0, slice_done=0.
  - Accumulator = OFFSET_INIT<<SLOPE_FRAC, so m_rcOffsetInit=OFFSET_INIT.
- Accumulator:
  - Width OFFSET_W+SLOPE_FRAC, unsigned.
  - m_rcOffsetInit = acc[OFFSET_W+SLOPE_FRAC-1:SLOPE_FRAC].
- slice_start, effective next edge:
  - acc=OFFSET_INIT<<SLOPE_FRAC, blk_cnt=0, slice_done=0.
  - Latch all config inputs; they are ignored until the next slice_start.
  - Compute Th = numBlksInSlice - numBlksInLine*thd, with the product at full width; clamp Th to 0 if the product exceeds numBlksInSlice.
  - Next state: DELAY if initTxDelay>0; else RAMP if Th==0; else HOLD.
  - Th arithmetic may be registered one cycle; blk_valid is never asserted in the cycle after slice_start.
- blk_valid in IDLE or after slice_done: ignored; no counter or offset change.
- DELAY on blk_valid:
  - acc -= AVE_BLK_BITS<<SLOPE_FRAC, saturating at 0.
  - blk_cnt++.
  - Equivalent rule: the block decrements iff (numPixelsCoded+BLK_PIX) <= initTxDelay*BLK_PIX.
  - Exit when blk_cnt+1 == initTxDelay: to RAMP if blk_cnt+1 >= Th, else HOLD.
- HOLD on blk_valid: blk_cnt++; if blk_cnt+1 >= Th go to RAMP.
- RAMP on blk_valid:
  - acc += slope, saturating at all-ones.
  - blk_cnt++.
  - A block ramps iff its pre-increment blk_cnt >= Th and the FSM has left DELAY; DELAY has priority when Th < initTxDelay.
- Slice completion:
  - When blk_cnt+1 == numBlksInSlice on blk_valid, set slice_done=1 and go to IDLE.
  - That block's own update is still applied.
  - If numBlksInSlice==0, slice_done asserts the cycle after slice_start.
- Latency: all outputs are registered and reflect a blk_valid one cycle later.
- Simultaneous slice_start and blk_valid: slice_start wins; the block is dropped.
- slice_start mid-slice aborts and restarts cleanly.
- Reset mid-slice returns to the reset state immediately.
- rc_phase is the registered state encoding.

Decomposition:
- Shared package: rc phase enum (IDLE/DELAY/HOLD/RAMP) and the OFFSET_INIT/AVE_BLK_BITS/BLK_PIX defaults, reused by the buffer-model and QP-update blocks.
- One natural sub-module: rc_sat_addsub, a parametrised saturating accumulator add/sub used for both the drain and the ramp.
- FSM and counters live in the top.

Test Plan:
1. Defaults; slice: numBlksInSlice=1350, numBlksInLine=120, thd=2 (Th=1110), initTxDelay=4, slope=0x010000; 1350 blk_valid pulses.
   -> Offset 8192, 8064, 7936, 7808, 7680 after blocks 1-4; phase HOLD at block 4.
   -> 7680 held through block 1110; +1 per block after.
   -> Final 7920; slice_done=1; phase IDLE.
2. initTxDelay=255, others as in 1.
   -> Offset reaches 0 after block 64 and stays 0 through block 255; no wrap.
3. thd=12 (product 1440 > 1350, Th clamped to 0), initTxDelay=2, slope=0x008000.
   -> Two drain blocks give 7936; next blk_valid enters RAMP.
   -> Offset increments by 1 every second block.
4. slope=0xFFFFFF with OFFSET_INIT at 65000, initTxDelay=0, Th=0.
   -> Offset saturates at 65535 and does not wrap.
5. slice_start asserted together with blk_valid mid-DELAY at offset 7808.
   -> Next cycle offset=8192, blk_cnt=0, phase DELAY; the coincident block is not counted.
6. rstn pulsed low mid-RAMP.
   -> Immediate offset 8192, phase IDLE, slice_done=0; subsequent blk_valid ignored until slice_start.
